// File: rtl/jtcop_paldma.sv
// Palette DMA: copies a 2-bank shadow buffer into the RG/B palette RAMs during vblank.
// One entry per clock; outputs are decoded from registered state, reads are 1-clk sync RAM.
module jtcop_paldma #(
  parameter int AW       = 10,
  parameter bit VBL_ONLY = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          trig,
  output logic [AW:0]   buf_addr,
  input  logic [15:0]   buf_dout,
  output logic [1:0]    pal_cs,
  output logic [AW-1:0] pal_addr,
  output logic [15:0]   pal_dout,
  output logic [1:0]    pal_dsn,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RG, BB, FLUSH} state_t;

  state_t        st, st_nx;
  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic [AW-1:0] ctr;
  logic [AW-1:0] wr_addr;
  logic          wr_vld, wr_bank;
  logic          pending;
  logic          active, issue, last, leave_idle;

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign active     = !LVBL || (VBL_ONLY == 1'b0);
  assign issue      = ((st == RG) || (st == BB)) && active;
  assign last       = &ctr;
  assign leave_idle = (st == IDLE) && pending && active;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) st <= IDLE;
    else            st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (leave_idle)    st_nx = RG;
      RG:      if (issue && last) st_nx = BB;
      BB:      if (issue && last) st_nx = FLUSH;
      FLUSH:   st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    buf_addr = {(st == BB), ctr};
    done     = (st == FLUSH);
    busy     = pending || (st != IDLE);
    pal_addr = wr_addr;
    pal_cs   = {wr_vld & wr_bank, wr_vld & ~wr_bank};
    pal_dsn  = 2'b11;
    pal_dout = 16'h0000;
    if (wr_vld) begin
      pal_dsn  = wr_bank ? 2'b10 : 2'b00;
      pal_dout = wr_bank ? {8'hff, buf_dout[7:0]} : buf_dout;
    end
  end

  // A trigger arriving in the same cycle the FSM leaves IDLE re-arms for another copy.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) pending <= 1'b0;
    else            pending <= trig || (pending && !leave_idle);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ctr     <= '0;
      wr_vld  <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_vld <= issue;
      if (leave_idle) begin
        ctr <= '0;
      end else if (issue) begin
        ctr     <= ctr + 1'b1;
        wr_bank <= (st == BB);
        wr_addr <= ctr;
      end
    end
  end

endmodule

// File: tb/tb_jtcop_paldma.sv
// Directed bench for jtcop_paldma: full copy, vblank wait, pause/resume, retrigger,
// mid-copy reset and the VBL_ONLY=0 variant.
module tb_jtcop_paldma;
  localparam int AW = 10;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          LVBL = 1'b1;
  logic          trig = 1'b0;
  logic          trig0 = 1'b0;
  logic [AW:0]   buf_addr, buf_addr0;
  logic [15:0]   buf_dout, buf_dout0;
  logic [1:0]    pal_cs, pal_cs0, pal_dsn, pal_dsn0;
  logic [AW-1:0] pal_addr, pal_addr0;
  logic [15:0]   pal_dout, pal_dout0;
  logic          busy, busy0, done, done0;

  logic [15:0] bufm [2*N];
  logic [15:0] rg_pal [N];
  logic [7:0]  b_pal [N];

  int nvec = 0, nerr = 0;
  int wr_cnt, done_cnt, done_cyc, busy_low, bad_strobe, seq_bad;
  int seq = 0;

  jtcop_paldma #(.AW(AW), .VBL_ONLY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .trig(trig),
    .buf_addr(buf_addr), .buf_dout(buf_dout), .pal_cs(pal_cs), .pal_addr(pal_addr),
    .pal_dout(pal_dout), .pal_dsn(pal_dsn), .busy(busy), .done(done));

  jtcop_paldma #(.AW(AW), .VBL_ONLY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .trig(trig0),
    .buf_addr(buf_addr0), .buf_dout(buf_dout0), .pal_cs(pal_cs0), .pal_addr(pal_addr0),
    .pal_dout(pal_dout0), .pal_dsn(pal_dsn0), .busy(busy0), .done(done0));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    buf_dout  <= bufm[buf_addr];
    buf_dout0 <= bufm[buf_addr0];
  end

  task automatic pulse_trig();
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
  endtask

  // Steps the clock, records palette writes and tallies protocol anomalies.
  task automatic watch(input int max_cyc, input int pause_at, input bit stop_done,
                       input int ta, input int tb);
    wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_low = 0; bad_strobe = 0; seq_bad = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      if (pause_at >= 0 && wr_cnt == pause_at) LVBL = 1'b1;
      trig = (c == ta) || (c == tb);
      @(negedge clk);
      case (pal_cs)
        2'b01: begin
          if (pal_dsn !== 2'b00) bad_strobe++;
          if (seq >= N || pal_addr !== AW'(seq)) seq_bad++;
          rg_pal[pal_addr] = pal_dout;
          seq++; wr_cnt++;
        end
        2'b10: begin
          if (pal_dsn !== 2'b10 || pal_dout[15:8] !== 8'hff) bad_strobe++;
          if (seq < N || pal_addr !== AW'(seq - N)) seq_bad++;
          b_pal[pal_addr] = pal_dout[7:0];
          seq++; wr_cnt++;
        end
        2'b00: if (pal_dsn !== 2'b11) bad_strobe++;
        default: bad_strobe++;
      endcase
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        if (seq != 2*N) seq_bad++;
        seq = 0;
        if (stop_done) break;
      end
    end
  endtask

  task automatic test_reset();
    nvec++; if (pal_cs !== 2'b00)      begin nerr++; $display("FAIL reset_cs got %b want 00", pal_cs); end
    nvec++; if (pal_dsn !== 2'b11)     begin nerr++; $display("FAIL reset_dsn got %b want 11", pal_dsn); end
    nvec++; if (pal_addr !== '0)       begin nerr++; $display("FAIL reset_addr got %h want 0", pal_addr); end
    nvec++; if (pal_dout !== 16'h0)    begin nerr++; $display("FAIL reset_dout got %h want 0", pal_dout); end
    nvec++; if (buf_addr !== '0)       begin nerr++; $display("FAIL reset_bufaddr got %h want 0", buf_addr); end
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
  endtask

  task automatic test_full_copy();
    LVBL = 1'b0;
    pulse_trig();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL full_busy_pending got %b want 1", busy); end
    watch(2200, -1, 1'b1, -1, -1);
    nvec++; if (wr_cnt != 2*N)   begin nerr++; $display("FAIL full_writes got %0d want %0d", wr_cnt, 2*N); end
    nvec++; if (done_cyc != 2049) begin nerr++; $display("FAIL full_done_cyc got %0d want 2049", done_cyc); end
    nvec++; if (seq_bad != 0 || bad_strobe != 0) begin nerr++; $display("FAIL full_order got seq_bad=%0d strobe=%0d want 0/0", seq_bad, bad_strobe); end
    nvec++; if (busy_low != 0)   begin nerr++; $display("FAIL full_busy got %0d low cycles want 0", busy_low); end
    nvec++; if (rg_pal[N-1] !== 16'h0BFD) begin nerr++; $display("FAIL full_rg1023 got %h want 0bfd", rg_pal[N-1]); end
    nvec++; if (b_pal[5] !== 8'hFA) begin nerr++; $display("FAIL full_b5 got %h want fa", b_pal[5]); end
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL full_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_wait_vblank();
    LVBL = 1'b1;
    pulse_trig();
    watch(50, -1, 1'b0, -1, -1);
    nvec++; if (wr_cnt != 0)   begin nerr++; $display("FAIL wait_nowrite got %0d want 0", wr_cnt); end
    nvec++; if (busy_low != 0) begin nerr++; $display("FAIL wait_busy got %0d low cycles want 0", busy_low); end
    LVBL = 1'b0;
    watch(2200, -1, 1'b1, -1, -1);
    nvec++; if (wr_cnt != 2*N || done_cyc != 2049) begin nerr++; $display("FAIL wait_copy got wr=%0d done=%0d want 2048/2049", wr_cnt, done_cyc); end
  endtask

  task automatic test_pause_resume();
    int bad;
    for (int i = 0; i < N; i++) begin
      bufm[i]     = 16'(i * 5 + 7);
      bufm[N + i] = 16'(i) ^ 16'h005a;
      rg_pal[i]   = 16'h0;
      b_pal[i]    = 8'h0;
    end
    LVBL = 1'b0;
    pulse_trig();
    watch(600, 300, 1'b0, -1, -1);
    nvec++; if (wr_cnt != 301)  begin nerr++; $display("FAIL pause_writes got %0d want 301", wr_cnt); end
    nvec++; if (busy_low != 0 || done_cnt != 0) begin nerr++; $display("FAIL pause_state got low=%0d done=%0d want 0/0", busy_low, done_cnt); end
    nvec++; if (bad_strobe != 0 || seq_bad != 0) begin nerr++; $display("FAIL pause_strobes got strobe=%0d seq=%0d want 0/0", bad_strobe, seq_bad); end
    LVBL = 1'b0;
    watch(2200, -1, 1'b1, -1, -1);
    nvec++; if (wr_cnt != 2*N - 301 || done_cnt != 1) begin nerr++; $display("FAIL resume_writes got %0d done=%0d want %0d/1", wr_cnt, done_cnt, 2*N - 301); end
    nvec++; if (seq_bad != 0) begin nerr++; $display("FAIL resume_order got %0d bad want 0", seq_bad); end
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (rg_pal[i] !== 16'(i * 5 + 7)) bad++;
      if (b_pal[i] !== (8'(i) ^ 8'h5a)) bad++;
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL resume_palette got %0d wrong entries want 0", bad); end
  endtask

  task automatic test_back_to_back();
    LVBL = 1'b0;
    pulse_trig();
    watch(5000, -1, 1'b0, 100, 900);
    nvec++; if (done_cnt != 2)   begin nerr++; $display("FAIL b2b_done got %0d want 2", done_cnt); end
    nvec++; if (wr_cnt != 4*N)   begin nerr++; $display("FAIL b2b_writes got %0d want %0d", wr_cnt, 4*N); end
    nvec++; if (seq_bad != 0)    begin nerr++; $display("FAIL b2b_order got %0d want 0", seq_bad); end
    nvec++; if (busy !== 1'b0)   begin nerr++; $display("FAIL b2b_busy got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    LVBL = 1'b0;
    pulse_trig();
    watch(502, -1, 1'b0, -1, -1);
    nvec++; if (wr_cnt != 501 || pal_addr !== AW'(500)) begin nerr++; $display("FAIL mreset_pre got wr=%0d addr=%0d want 501/500", wr_cnt, pal_addr); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    nvec++; if (pal_cs !== 2'b00 || pal_dsn !== 2'b11) begin nerr++; $display("FAIL mreset_strobes got cs=%b dsn=%b want 00/11", pal_cs, pal_dsn); end
    nvec++; if (pal_addr !== '0 || pal_dout !== 16'h0 || buf_addr !== '0) begin nerr++; $display("FAIL mreset_bus got addr=%h dout=%h baddr=%h want 0", pal_addr, pal_dout, buf_addr); end
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL mreset_busy got %b%b want 00", busy, done); end
    @(negedge clk) rst_n = 1'b1;
    seq = 0;
    watch(100, -1, 1'b0, -1, -1);
    nvec++; if (wr_cnt != 0 || busy_low != 100) begin nerr++; $display("FAIL mreset_quiet got wr=%0d low=%0d want 0/100", wr_cnt, busy_low); end
  endtask

  task automatic test_vbl_any();
    int w0, first0, dc0;
    w0 = 0; first0 = -1; dc0 = -1;
    LVBL = 1'b1;
    @(negedge clk) trig0 = 1'b1;
    @(negedge clk) trig0 = 1'b0;
    nvec++; if (busy0 !== 1'b1) begin nerr++; $display("FAIL any_busy got %b want 1", busy0); end
    for (int c = 1; c <= 2200; c++) begin
      @(negedge clk);
      if (pal_cs0 != 2'b00) begin
        w0++;
        if (first0 < 0) first0 = c;
      end
      if (done0 === 1'b1) begin dc0 = c; break; end
    end
    nvec++; if (first0 != 2)   begin nerr++; $display("FAIL any_first got %0d want 2", first0); end
    nvec++; if (w0 != 2*N || dc0 != 2049) begin nerr++; $display("FAIL any_copy got wr=%0d done=%0d want 2048/2049", w0, dc0); end
    nvec++; if (pal_cs !== 2'b00 || busy !== 1'b0) begin nerr++; $display("FAIL any_other got cs=%b busy=%b want 00/0", pal_cs, busy); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      bufm[i]     = 16'(i * 3);
      bufm[N + i] = ~16'(i);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_full_copy();
    test_wait_vblank();
    test_pause_resume();
    test_back_to_back();
    test_mid_reset();
    test_vbl_any();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
